fix_stream_arb: RTL and testbench
=================================

FIX_STREAM_ARB -- requirements
Module: fix_stream_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter IDLE_MAX, default 255, stall cycles tolerated within a message before abort.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data_i  input  NUM_REQ x 8  per-requester FIX byte.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 SHALL have port par_data_o  output  8  byte forwarded to the fix_parser data_i.
REQ-009 SHALL have port par_ctrl_o  output  1  forwarded-byte strobe to the fix_parser ctrl.
REQ-010 SHALL have port par_src_o  output  $clog2(NUM_REQ)  index of the requester owning par_data_o.
REQ-011 SHALL have port eom_o  output  1  pulse with the SOH that terminates tag 10 (CheckSum).
REQ-012 SHALL have port abort_o  output  1  one-cycle pulse when a message is abandoned on timeout.
REQ-013 SHALL have port busy_o  output  1  high while a grant is held.

Function
REQ-014 SHALL implement FSM states ARB, XFER; reset state ARB.
REQ-015 In ARB: all req_ready_o low; if any req_valid_i high, grant the first valid index after the last granted index (round-robin, wrapping NUM_REQ-1 -> 0), enter XFER next cycle; otherwise stay in ARB.
REQ-016 After reset the round-robin pointer SHALL be NUM_REQ-1, so requester 0 wins first.
REQ-017 In XFER: req_ready_o[grant] SHALL be high; a byte transfers when req_valid_i[grant] and req_ready_o[grant] are both high.
REQ-018 A transferred byte SHALL appear on par_data_o with par_ctrl_o high exactly 1 cycle later; par_src_o = grant on that cycle.
REQ-019 Message-boundary tracker SHALL treat the first byte after a grant, and every byte after SOH (8'h01), as the start of a tag.
REQ-020 Tracker SHALL flag the checksum field when the tag bytes are exactly '1','0' followed by '=' (8'h3D); any other tag clears the flag.
REQ-021 The SOH ending the checksum value SHALL be forwarded with eom_o high on the same cycle as its par_ctrl_o; ready SHALL drop in the cycle after its transfer and the FSM SHALL return to ARB.
REQ-022 Grant SHALL never change mid-message; other requesters wait regardless of validity.
REQ-023 Non-transfer cycles in XFER SHALL increment an 8-bit+ idle counter, cleared on each transfer and on grant.
REQ-024 Simultaneous valid on all requesters SHALL yield strict rotation 0,1,2,...,NUM_REQ-1,0 by message.
REQ-025 par_ctrl_o, eom_o, abort_o SHALL be low on every cycle without a forwarded byte (abort_o excepted per REQ-028).

Reset
REQ-026 On rst low, asynchronously: state ARB, pointer NUM_REQ-1, tracker at tag start, counters 0, and all outputs 0.
REQ-027 Reset mid-message SHALL discard the partial message with no eom_o or abort_o pulse.

Configuration
REQ-028 With macro FIX_STREAM_ARB_TIMEOUT_EN defined: when the idle counter reaches IDLE_MAX in XFER, abort_o pulses one cycle, ready drops, FSM returns to ARB, pointer advances past the aborted requester.
REQ-029 Without FIX_STREAM_ARB_TIMEOUT_EN: no idle counter, abort_o tied 0, grant held indefinitely until eom.

Structure
REQ-030 Package fix_pkg SHALL hold SOH_C (8'h01), SEP_C (8'h3D), the ARB/XFER state enum and the tracker state enum.
REQ-031 Boundary tracker SHALL be a sub-module fix_eom_detect (inputs byte + strobe + restart; output eom).

Verification
REQ-032 Req0 sends "8=FIX.4.2^9=5^35=0^10=123^" unstalled -> bytes on par_data_o 1 cycle later, par_src_o=0, eom_o with final SOH, busy_o low 1 cycle after.
REQ-033 All 4 requesters valid with one message each -> messages forwarded in order 0,1,2,3 with no interleaving.
REQ-034 Message containing "110=5^" and "101=7^" before "10=044^" -> eom_o only on SOH after "044".
REQ-035 TIMEOUT_EN, req1 stalls 255 cycles mid-value -> abort_o one pulse, next grant to req2 if valid.
REQ-036 rst asserted low mid-message on req2 -> all outputs 0 immediately; after release req0 granted first.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared constants and state encodings for the FIX stream arbiter and its
// message-boundary tracker.
package fix_pkg;

  localparam logic [7:0] SOH_C      = 8'h01;
  localparam logic [7:0] SEP_C      = 8'h3D;
  localparam logic [7:0] CH_ONE_C   = 8'h31;
  localparam logic [7:0] CH_ZERO_C  = 8'h30;

  typedef enum logic {
    ARB,
    XFER
  } arb_state_e;

  // T_ONE / T_ONEZERO track a tag that so far reads "1" / "10";
  // T_CSVAL is the value field of tag 10 (CheckSum).
  typedef enum logic [2:0] {
    T_START,
    T_ONE,
    T_ONEZERO,
    T_TAG,
    T_VAL,
    T_CSVAL
  } trk_state_e;

endpackage

// File: rtl/fix_eom_detect.sv
// FIX message-boundary tracker: flags the SOH that terminates the CheckSum
// (tag 10) field of the byte stream it observes.
module fix_eom_detect
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       strobe,
  input  logic       restart,
  output logic       eom
);

  trk_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = T_START;
    end else if (strobe) begin
      if (data == SOH_C) begin
        state_d = T_START;
      end else begin
        case (state_q)
          T_START: begin
            if (data == CH_ONE_C)   state_d = T_ONE;
            else if (data == SEP_C) state_d = T_VAL;
            else                    state_d = T_TAG;
          end
          T_ONE: begin
            if (data == CH_ZERO_C)  state_d = T_ONEZERO;
            else if (data == SEP_C) state_d = T_VAL;
            else                    state_d = T_TAG;
          end
          T_ONEZERO: begin
            if (data == SEP_C)      state_d = T_CSVAL;
            else                    state_d = T_TAG;
          end
          T_TAG: begin
            if (data == SEP_C)      state_d = T_VAL;
          end
          T_VAL, T_CSVAL: begin
            state_d = state_q;
          end
          default: state_d = T_START;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= T_START;
    end else begin
      state_q <= state_d;
    end
  end

  assign eom = strobe && !restart && (data == SOH_C) && (state_q == T_CSVAL);

endmodule

// File: rtl/fix_stream_arb.sv
// Round-robin arbiter that forwards whole FIX messages from NUM_REQ byte
// streams to one parser. Optional stall timeout: FIX_STREAM_ARB_TIMEOUT_EN.
module fix_stream_arb
  import fix_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDLE_MAX = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0][7:0]      req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [7:0]                   par_data_o,
  output logic                         par_ctrl_o,
  output logic [$clog2(NUM_REQ)-1:0]   par_src_o,
  output logic                         eom_o,
  output logic                         abort_o,
  output logic                         busy_o
);

  localparam int SRC_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDLE_MAX < 1) begin : g_bad_cfg
    $error("fix_stream_arb: unsupported NUM_REQ or IDLE_MAX");
  end

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  grant_q;
  logic [SRC_W-1:0]  last_q;
  logic [SRC_W-1:0]  pick;
  logic              any_vld;
  logic              grant_en;
  logic              timeout;
  logic              eom_det;

  logic [7:0]        data_p0;
  logic              vld_p0;

  logic [7:0]        data_p1;
  logic              vld_p1;
  logic [SRC_W-1:0]  src_p1;
  logic              eom_p1;

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin
    pick    = last_q;
    any_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_vld && req_valid_i[(int'(last_q) + i) % NUM_REQ]) begin
        any_vld = 1'b1;
        pick    = SRC_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  assign data_p0 = req_data_i[grant_q];
  assign vld_p0  = (state_q == XFER) && !timeout && req_valid_i[grant_q];

  always_comb begin
    req_ready_o = '0;
    if (state_q == XFER && !timeout) begin
      req_ready_o[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ARB: begin
        if (any_vld) begin
          grant_en = 1'b1;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (timeout || (vld_p0 && eom_det)) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // The pointer moves at grant time, so both completed and aborted
  // messages hand priority to the next requester in rotation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      last_q  <= SRC_W'(NUM_REQ - 1);
    end else if (grant_en) begin
      grant_q <= pick;
      last_q  <= pick;
    end
  end

  fix_eom_detect u_eom (
    .clk     (clk),
    .rst     (rst),
    .data    (data_p0),
    .strobe  (vld_p0),
    .restart (grant_en),
    .eom     (eom_det)
  );

`ifdef FIX_STREAM_ARB_TIMEOUT_EN
  localparam int IDLE_W = (IDLE_MAX > 255) ? $clog2(IDLE_MAX + 1) : 8;

  logic [IDLE_W-1:0] idle_q;
  logic              abort_p1;

  assign timeout = (state_q == XFER) && (idle_q == IDLE_W'(IDLE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else if (grant_en || vld_p0 || state_q != XFER) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_W'(IDLE_MAX)) begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_p1 <= 1'b0;
    end else begin
      abort_p1 <= timeout;
    end
  end

  assign abort_o = abort_p1;
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

  // p0 -> p1: accepted byte is presented to the parser one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      eom_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      eom_p1 <= vld_p0 && eom_det;
      if (vld_p0) begin
        data_p1 <= data_p0;
        src_p1  <= grant_q;
      end
    end
  end

  assign par_data_o = data_p1;
  assign par_ctrl_o = vld_p1;
  assign par_src_o  = src_p1;
  assign eom_o      = eom_p1;
  assign busy_o     = (state_q == XFER);

endmodule

// File: tb/tb_fix_stream_arb.sv
// Directed bench for fix_stream_arb: cycle table plus message-level sequences.
`timescale 1ns/1ps
module tb_fix_stream_arb;
  import fix_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0][7:0] req_data = '0;
  logic [N-1:0]      req_ready_o;
  logic [7:0]        par_data_o;
  logic              par_ctrl_o;
  logic [1:0]        par_src_o;
  logic              eom_o;
  logic              abort_o;
  logic              busy_o;

  always #5 clk = ~clk;

  fix_stream_arb #(.NUM_REQ(N), .IDLE_MAX(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .par_data_o  (par_data_o),
    .par_ctrl_o  (par_ctrl_o),
    .par_src_o   (par_src_o),
    .eom_o       (eom_o),
    .abort_o     (abort_o),
    .busy_o      (busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  string msg [N];

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  rdy;
    logic        ctrl;
    logic [7:0]  pd;
    logic [1:0]  src;
    logic        eom;
    logic        busy;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_ready_o, par_ctrl_o, par_data_o, par_src_o, eom_o, abort_o, busy_o});
  endfunction

  function automatic logic [7:0] chr(input string s, input int i);
    logic [7:0] c;
    c = s[i];
    return (c == 8'h5E) ? SOH_C : c;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    #2 rst = 1'b0;
    #1 check("reset_outputs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // Drives the active requesters' messages and checks every parser-side cycle.
  task automatic run_msgs(input logic [3:0] act, input logic [7:0] order,
                          input int stall_r, input int stall_k, input int stall_len);
    int k [N];
    int pos, cur, left, rx, exp_src;
    logic [3:0] rdy_prev, vld_prev, exp_rdy, act_rdy;
    logic last;
    bit done;
    pos  = 0;
    cur  = -1;
    left = stall_len;
    done = 1'b0;
    for (int r = 0; r < N; r++) k[r] = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      for (int r = 0; r < N; r++) begin
        req_valid[r] = act[r] && (k[r] < msg[r].len());
        req_data[r]  = req_valid[r] ? chr(msg[r], k[r]) : 8'h00;
        if (req_valid[r] && r == stall_r && k[r] == stall_k && left > 0) begin
          req_valid[r] = 1'b0;
          left--;
        end
      end
      rdy_prev = req_ready_o;
      vld_prev = req_valid;
      step();
      rx = -1;
      for (int r = 0; r < N; r++) if (rdy_prev[r] && vld_prev[r]) rx = r;
      if (rx >= 0) begin
        exp_src = (cur >= 0) ? cur : ((pos < 4) ? int'(order[2*pos +: 2]) : 0);
        last    = (k[rx] == msg[rx].len() - 1);
        check($sformatf("byte r%0d k%0d", rx, k[rx]),
              64'({par_ctrl_o, par_data_o, par_src_o, 2'(rx), eom_o, abort_o}),
              64'({1'b1, chr(msg[rx], k[rx]), 2'(exp_src), 2'(exp_src), last, 1'b0}));
        if (cur < 0) begin
          cur = exp_src;
          pos++;
        end
        k[rx]++;
        if (last) begin
          cur = -1;
          check("eom_release", 64'({busy_o, req_ready_o}), 64'd0);
        end
      end else begin
        exp_rdy = (cur >= 0) ? 4'(1 << cur) : 4'b0;
        act_rdy = (cur >= 0) ? req_ready_o : 4'b0;
        check("idle_cycle",
              64'({par_ctrl_o, eom_o, abort_o, ($countones(req_ready_o) > 1), act_rdy}),
              64'({4'b0000, exp_rdy}));
      end
      done = 1'b1;
      for (int r = 0; r < N; r++) if (act[r] && k[r] < msg[r].len()) done = 1'b0;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL run_msgs: cycle budget exhausted, got pending bytes, required all delivered");
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // vld, {d3,d2,d1,d0}, rdy, ctrl, pd, src, eom, busy
    tbl[0]  = '{4'b0101, 32'h0058_0031, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0101, 32'h0058_0031, 4'b0001, 1'b1, 8'h31, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{4'b0101, 32'h0058_0030, 4'b0001, 1'b1, 8'h30, 2'd0, 1'b0, 1'b1};
    tbl[3]  = '{4'b0101, 32'h0058_003D, 4'b0001, 1'b1, 8'h3D, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{4'b0100, 32'h0058_0000, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{4'b0101, 32'h0058_0035, 4'b0001, 1'b1, 8'h35, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{4'b0101, 32'h0058_0001, 4'b0000, 1'b1, 8'h01, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{4'b0101, 32'h0039_0031, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[8]  = '{4'b0101, 32'h0039_0031, 4'b0100, 1'b1, 8'h39, 2'd2, 1'b0, 1'b1};
    tbl[9]  = '{4'b0101, 32'h0001_0031, 4'b0100, 1'b1, 8'h01, 2'd2, 1'b0, 1'b1};
    tbl[10] = '{4'b0101, 32'h0031_0031, 4'b0100, 1'b1, 8'h31, 2'd2, 1'b0, 1'b1};
    tbl[11] = '{4'b0101, 32'h0030_0031, 4'b0100, 1'b1, 8'h30, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{4'b0101, 32'h003D_0031, 4'b0100, 1'b1, 8'h3D, 2'd2, 1'b0, 1'b1};
    tbl[13] = '{4'b0101, 32'h0001_0031, 4'b0000, 1'b1, 8'h01, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{4'b1001, 32'h3800_0031, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[15] = '{4'b1001, 32'h3800_0031, 4'b1000, 1'b1, 8'h38, 2'd3, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].vld;
      req_data  = tbl[i].dat;
      step();
      check($sformatf("vec%0d", i),
            64'({req_ready_o, par_ctrl_o, (tbl[i].ctrl ? par_data_o : 8'h00),
                 (tbl[i].ctrl ? par_src_o : 2'd0), eom_o, abort_o, busy_o}),
            64'({tbl[i].rdy, tbl[i].ctrl, tbl[i].pd, tbl[i].src, tbl[i].eom, 1'b0, tbl[i].busy}));
    end

    // Single unstalled message from requester 0.
    do_reset();
    msg[0] = "8=FIX.4.2^9=5^35=0^10=123^";
    run_msgs(4'b0001, 8'h00, -1, 0, 0);

    // All four requesters contending: whole messages in order 0,1,2,3.
    do_reset();
    msg[0] = "8=FIX.4.2^10=001^";
    msg[1] = "35=A^10=002^";
    msg[2] = "9=3^10=003^";
    msg[3] = "10=004^";
    run_msgs(4'b1111, 8'b11_10_01_00, -1, 0, 0);

    // Look-alike tags and a "10=" inside a value must not end the message.
    msg[1] = "8=FIX.4.2^110=5^101=7^10=044^";
    msg[2] = "58=A10=9^10=000^";
    run_msgs(4'b0110, 8'b0000_10_01, -1, 0, 0);

`ifdef FIX_STREAM_ARB_TIMEOUT_EN
    do_reset();
    req_valid = 4'b0010;
    req_data[1] = 8'h31;
    step();
    check("to_grant", 64'({req_ready_o, busy_o}), 64'({4'b0010, 1'b1}));
    req_data[1] = 8'h31; step();
    req_data[1] = 8'h30; step();
    req_data[1] = 8'h3D; step();
    req_data[1] = 8'h31; step();
    check("to_last_byte", 64'({par_ctrl_o, par_data_o}), 64'({1'b1, 8'h31}));
    req_valid = 4'b0100;
    req_data[2] = 8'h38;
    cnt = 0;
    while (!abort_o && cnt < 400) begin
      step();
      cnt++;
    end
    check("to_abort_latency", 64'(cnt), 64'd256);
    check("to_abort_cycle", 64'({abort_o, eom_o, par_ctrl_o, req_ready_o, busy_o}),
          64'({1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}));
    step();
    check("to_after_abort", 64'({abort_o, req_ready_o, busy_o}), 64'({1'b0, 4'b0100, 1'b1}));
    req_valid = '0;
`else
    // Long stall: grant is held, no abort, message still completes.
    do_reset();
    msg[1] = "10=123^";
    msg[2] = "9=1^10=000^";
    run_msgs(4'b0110, 8'b0000_10_01, 1, 4, 300);
`endif

    // Reset in the middle of a message on requester 2.
    do_reset();
    req_valid = 4'b0100;
    req_data[2] = 8'h38;
    step();
    step();
    req_data[2] = 8'h3D;
    step();
    check("pre_reset", 64'({busy_o, par_ctrl_o, par_data_o, par_src_o}),
          64'({1'b1, 1'b1, 8'h3D, 2'd2}));
    do_reset();
    req_valid = 4'b0101;
    req_data  = 32'h0038_0038;
    step();
    check("post_reset_grant", 64'({req_ready_o, busy_o, eom_o, abort_o, par_ctrl_o}),
          64'({4'b0001, 1'b1, 1'b0, 1'b0, 1'b0}));
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
